// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for the 8-bit CPU program ROM.
// It owns the program counter and drives the ROM address and strobes.
// It decodes only the control-flow opcodes JMP and HLT.
// Every other instruction byte goes to execute over a valid/ready handshake.
module fetch_ctrl #(
    parameter int            AW       = 8,
    parameter int            DW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [3:0]    JMP_OP   = 4'hA,
    parameter logic [3:0]    HLT_OP   = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] rom_data,
    output logic [AW-1:0] rom_addr,
    output logic          rom_read,
    output logic          rom_ena,
    output logic [DW-1:0] ir,
    output logic          ir_valid,
    input  logic          ir_ready,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        JUMP  = 3'd2,
        ISSUE = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [AW-1:0] PC_ONE = 1;

    state_t        state, state_nx;
    logic [AW-1:0] pc_nx;
    logic [DW-1:0] ir_nx;
    logic          ir_valid_nx;
    logic          halted_nx;
    logic [3:0]    op;

    // Only the upper nibble of a fetched byte matters for control flow.
    assign op = rom_data[DW-1:DW-4];

    // Outputs decode from registered state and pc only.
    // The ROM is enabled solely in the two states that sample rom_data.
    assign rom_addr = pc;
    assign rom_read = (state == FETCH) || (state == JUMP);
    assign rom_ena  = rom_read;
    assign busy     = (state != IDLE) && (state != HALT);

    // State, pc, ir and flags update together; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop load pre-edge values, so
        // the order of these statements cannot change behaviour.
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            ir       <= ir_nx;
            ir_valid <= ir_valid_nx;
            halted   <= halted_nx;
        end
    end

    // Next-state and datapath decode.
    // rom_data is consulted only in FETCH and JUMP.
    always_comb begin
        // NOTE: every value written here is defaulted to its current register first,
        // so no path leaves it unassigned and no latch is inferred.
        state_nx    = state;
        pc_nx       = pc;
        ir_nx       = ir;
        ir_valid_nx = ir_valid;
        halted_nx   = halted;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = FETCH;
                end
            end

            FETCH: begin
                if (op == HLT_OP) begin
                    // pc stays on the HLT byte, and the byte is not issued.
                    state_nx  = HALT;
                    halted_nx = 1'b1;
                end else if (op == JMP_OP) begin
                    // Step onto the operand byte; the JMP byte itself is consumed here.
                    pc_nx    = pc + PC_ONE;
                    state_nx = JUMP;
                end else begin
                    ir_nx       = rom_data;
                    ir_valid_nx = 1'b1;
                    pc_nx       = pc + PC_ONE;
                    state_nx    = ISSUE;
                end
            end

            JUMP: begin
                // The operand is an absolute target.
                // The byte at the target is fetched normally, whatever its opcode.
                pc_nx    = rom_data[AW-1:0];
                state_nx = FETCH;
            end

            ISSUE: begin
                if (ir_ready) begin
                    ir_valid_nx = 1'b0;
                    state_nx    = FETCH;
                end
            end

            HALT: begin
                state_nx = HALT;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl.
// Three instances run with reset PCs 00, 07 and FF, sharing one ROM image.
// A behavioural model predicts every output on every cycle.
// Directed scenarios pin the model with literal expectations, then randomised
// programs and handshakes exercise the rest.
module tb_fetch_ctrl;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ir_ready = 1'b0;
    logic       start_v   [N];
    logic [7:0] rom       [256];

    logic [7:0] rom_data_w [N];
    logic [7:0] rom_addr_w [N];
    logic       rom_read_w [N];
    logic       rom_ena_w  [N];
    logic [7:0] ir_w       [N];
    logic       ir_valid_w [N];
    logic [7:0] pc_w       [N];
    logic       halted_w   [N];
    logic       busy_w     [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_rom
        assign rom_data_w[g] = rom[rom_addr_w[g]];
    end

    fetch_ctrl #(.RESET_PC(8'h00)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .rom_data(rom_data_w[0]),
        .rom_addr(rom_addr_w[0]), .rom_read(rom_read_w[0]), .rom_ena(rom_ena_w[0]),
        .ir(ir_w[0]), .ir_valid(ir_valid_w[0]), .ir_ready(ir_ready),
        .pc(pc_w[0]), .halted(halted_w[0]), .busy(busy_w[0]));

    fetch_ctrl #(.RESET_PC(8'h07)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .rom_data(rom_data_w[1]),
        .rom_addr(rom_addr_w[1]), .rom_read(rom_read_w[1]), .rom_ena(rom_ena_w[1]),
        .ir(ir_w[1]), .ir_valid(ir_valid_w[1]), .ir_ready(ir_ready),
        .pc(pc_w[1]), .halted(halted_w[1]), .busy(busy_w[1]));

    fetch_ctrl #(.RESET_PC(8'hFF)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .rom_data(rom_data_w[2]),
        .rom_addr(rom_addr_w[2]), .rom_read(rom_read_w[2]), .rom_ena(rom_ena_w[2]),
        .ir(ir_w[2]), .ir_valid(ir_valid_w[2]), .ir_ready(ir_ready),
        .pc(pc_w[2]), .halted(halted_w[2]), .busy(busy_w[2]));

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[u%0d] at %0t: got %0h, expected %0h", name, idx, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each instance is idle, running or halted.  While running, it is either
    // waiting on a hand-off (m_valid), due to read a jump target (m_opnd),
    // or due to read an opcode.
    logic [7:0] m_pc    [N];
    logic [7:0] m_ir    [N];
    logic       m_valid [N];
    logic       m_run   [N];
    logic       m_halted[N];
    logic       m_opnd  [N];
    bit         model_ok = 1'b0;

    function automatic logic [7:0] reset_pc(input int i);
        return (i == 0) ? 8'h00 : (i == 1) ? 8'h07 : 8'hFF;
    endfunction

    // Model advances on the same edge as the DUTs, from the same stable inputs.
    always @(posedge clk) begin
        logic [7:0] b;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_pc[i] = reset_pc(i); m_ir[i] = 8'h00; m_valid[i] = 1'b0;
                m_run[i] = 1'b0; m_halted[i] = 1'b0; m_opnd[i] = 1'b0;
            end else if (m_halted[i]) begin
                // terminal
            end else if (!m_run[i]) begin
                if (start_v[i]) m_run[i] = 1'b1;
            end else if (m_valid[i]) begin
                if (ir_ready) m_valid[i] = 1'b0;
            end else if (m_opnd[i]) begin
                m_pc[i] = rom[m_pc[i]];
                m_opnd[i] = 1'b0;
            end else begin
                b = rom[m_pc[i]];
                if (b[7:4] == 4'hF) begin
                    m_halted[i] = 1'b1; m_run[i] = 1'b0;
                end else if (b[7:4] == 4'hA) begin
                    m_pc[i] = m_pc[i] + 8'd1; m_opnd[i] = 1'b1;
                end else begin
                    m_ir[i] = b; m_valid[i] = 1'b1; m_pc[i] = m_pc[i] + 8'd1;
                end
            end
        end
        if (rst) model_ok = 1'b1;
    end

    // Bytes handed over by the instance selected in `sel`.
    int         sel = 0;
    logic [7:0] issued [$];

    // Compare every instance against the model on every falling edge.
    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < N; i++) begin
                check("pc",       i, pc_w[i],       m_pc[i]);
                check("rom_addr", i, rom_addr_w[i], m_pc[i]);
                check("rom_ena",  i, rom_ena_w[i],  m_run[i] && !m_valid[i]);
                check("rom_read", i, rom_read_w[i], m_run[i] && !m_valid[i]);
                check("busy",     i, busy_w[i],     m_run[i]);
                check("halted",   i, halted_w[i],   m_halted[i]);
                check("ir_valid", i, ir_valid_w[i], m_valid[i]);
                check("ir",       i, ir_w[i],       m_ir[i]);
            end
            if (!rst && ir_ready && ir_valid_w[sel] === 1'b1) issued.push_back(ir_w[sel]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        issued.delete();
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int a = 0; a < 256; a++) rom[a] = v;
    endtask

    task automatic pulse_start(input int i);
        start_v[i] = 1'b1;
        step();
        start_v[i] = 1'b0;
    endtask

    task automatic wait_halt(input int i, input int budget);
        int n = 0;
        while (halted_w[i] !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("halt_reached", i, halted_w[i], 1'b1);
    endtask

    task automatic check_issued(input string name, input logic [7:0] exp [$]);
        check({name, "_count"}, sel, issued.size(), exp.size());
        for (int k = 0; k < exp.size() && k < issued.size(); k++)
            check({name, "_byte"}, sel, issued[k], exp[k]);
    endtask

    // ---------------- directed and random scenarios ----------------
    initial begin
        for (int i = 0; i < N; i++) start_v[i] = 1'b0;
        fill_rom(8'hF0);

        // Reset, then stay idle.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            check("idle_pc",   0, pc_w[0], 8'h00);
            check("idle_busy", 0, busy_w[0], 1'b0);
            check("idle_ena",  0, rom_ena_w[0], 1'b0);
            step();
        end

        // Straight-line issue ending on HLT.
        sel = 0;
        fill_rom(8'hF0);
        rom[0] = 8'h00; rom[1] = 8'h81; rom[2] = 8'h81;
        rom[3] = 8'h81; rom[4] = 8'h91; rom[5] = 8'h73; rom[6] = 8'hF0;
        ir_ready = 1'b1;
        do_reset();
        pulse_start(0);
        wait_halt(0, 40);
        check_issued("straight", '{8'h00, 8'h81, 8'h81, 8'h81, 8'h91, 8'h73});
        check("straight_pc",  0, pc_w[0], 8'h06);
        check("straight_ena", 0, rom_ena_w[0], 1'b0);

        // JMP from 07 to 0F.
        sel = 1;
        fill_rom(8'hF0);
        rom[7] = 8'hA3; rom[8] = 8'h0F; rom[15] = 8'h81; rom[16] = 8'hF0;
        do_reset();
        pulse_start(1);
        check("jmp_fetch_pc", 1, pc_w[1], 8'h07);
        step();
        check("jmp_operand_pc", 1, pc_w[1], 8'h08);
        step();
        check("jmp_target_pc", 1, pc_w[1], 8'h0F);
        wait_halt(1, 20);
        check_issued("jmp", '{8'h81});
        check("jmp_halt_pc", 1, pc_w[1], 8'h10);

        // Back-pressure.
        sel = 0;
        fill_rom(8'hF0);
        rom[0] = 8'h81; rom[1] = 8'hF0;
        ir_ready = 1'b0;
        do_reset();
        pulse_start(0);
        step();
        for (int c = 0; c < 4; c++) begin
            check("bp_ir",    0, ir_w[0], 8'h81);
            check("bp_valid", 0, ir_valid_w[0], 1'b1);
            check("bp_pc",    0, pc_w[0], 8'h01);
            check("bp_ena",   0, rom_ena_w[0], 1'b0);
            step();
        end
        ir_ready = 1'b1;
        step();
        check("bp_release_valid", 0, ir_valid_w[0], 1'b0);
        check("bp_release_ena",   0, rom_ena_w[0], 1'b1);
        step();
        check("bp_halted", 0, halted_w[0], 1'b1);
        check("bp_halt_pc", 0, pc_w[0], 8'h01);

        // Wrap-around, for both an issue and a jump operand.
        sel = 2;
        fill_rom(8'hF0);
        rom[8'hFF] = 8'h81; rom[8'h00] = 8'hF0;
        do_reset();
        pulse_start(2);
        wait_halt(2, 20);
        check_issued("wrap", '{8'h81});
        check("wrap_pc", 2, pc_w[2], 8'h00);
        rom[8'hFF] = 8'hA0; rom[8'h00] = 8'h05; rom[8'h05] = 8'hF0;
        do_reset();
        pulse_start(2);
        step();
        check("wrap_jmp_operand_pc", 2, pc_w[2], 8'h00);
        step();
        check("wrap_jmp_target_pc", 2, pc_w[2], 8'h05);
        wait_halt(2, 20);
        check("wrap_jmp_issued", 2, issued.size(), 0);

        // Reset during ISSUE with ir_ready low.
        sel = 0;
        fill_rom(8'hF0);
        rom[0] = 8'h81; rom[7] = 8'hA3; rom[8] = 8'h0F; rom[15] = 8'h81; rom[16] = 8'hF0;
        ir_ready = 1'b0;
        do_reset();
        pulse_start(0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_issue_pc",     0, pc_w[0], 8'h00);
        check("rst_issue_valid",  0, ir_valid_w[0], 1'b0);
        check("rst_issue_busy",   0, busy_w[0], 1'b0);
        check("rst_issue_halted", 0, halted_w[0], 1'b0);
        check("rst_issue_issued", 0, issued.size(), 0);
        pulse_start(0);
        check("rst_refetch_pc",  0, pc_w[0], 8'h00);
        check("rst_refetch_ena", 0, rom_ena_w[0], 1'b1);

        // Reset during JUMP.
        do_reset();
        pulse_start(1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_jump_pc",   1, pc_w[1], 8'h07);
        check("rst_jump_busy", 1, busy_w[1], 1'b0);

        // Randomised programs, start pulses, back-pressure and occasional resets.
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
            do_reset();
            for (int c = 0; c < 400; c++) begin
                for (int i = 0; i < N; i++) start_v[i] = ($urandom_range(0, 7) == 0);
                ir_ready = 1'($urandom_range(0, 1));
                rst = ($urandom_range(0, 63) == 0);
                step();
            end
            rst = 1'b0;
            for (int i = 0; i < N; i++) start_v[i] = 1'b0;
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
